// File: rtl/cnn_mem_pkg.sv
// Shared types and constants for the CNN output-memory path.
package cnn_mem_pkg;

   typedef logic [7:0] byte_t;
   typedef byte_t [0:3] word_bytes_t;

   localparam int WORD_BYTES        = 4;
   localparam int DEFAULT_NUM_WORDS = 43;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_DONE
   } arb_state_t;

   // Byte address to word index.
   function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
      return byte_addr >> $clog2(WORD_BYTES);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search begins one past ptr and wraps.
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] winner,
   output logic                    any
);

   localparam int PW = $clog2(NREQ);

   always_comb begin
      int idx;
      gnt    = '0;
      winner = '0;
      any    = 1'b0;
      idx    = 0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!any && req[idx]) begin
            gnt[idx] = 1'b1;
            winner   = PW'(idx);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_write_arbiter.sv
// Round-robin sharing of write_memory's write port; raises done after NUM_WORDS commits.
// Optional out-of-range address check: define MEM_WR_ARB_RANGE_CHECK_EN.
module mem_write_arbiter
   import cnn_mem_pkg::*;
#(
   parameter  int NREQ      = 4,
   parameter  int WIDTH     = 64,
   parameter  int NUM_WORDS = DEFAULT_NUM_WORDS,
   localparam int AW        = $clog2(WIDTH),
   localparam int CW        = $clog2(NUM_WORDS + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic        [NREQ-1:0]     req,
   input  logic        [NREQ-1:0][AW-1:0] req_addr,
   input  word_bytes_t [NREQ-1:0]     req_data,
   output logic        [NREQ-1:0]     gnt,
   output logic                       write_en,
   output logic        [AW-1:0]       addr,
   output word_bytes_t                inp,
   output logic        [CW-1:0]       words_written,
   output logic                       done,
   output logic                       err
);

   localparam int PW = $clog2(NREQ);

   arb_state_t     state_reg, state_next;
   logic [PW-1:0]  ptr_reg;
   logic           write_en_reg, write_en_next;
   logic [AW-1:0]  addr_reg;
   word_bytes_t    inp_reg;
   logic [CW-1:0]  count_reg;
   logic           err_reg, err_next;

   logic [NREQ-1:0] arb_gnt;
   logic [PW-1:0]   winner;
   logic            arb_any;
   logic            grant_ok;
   logic            fire;
   logic            in_range;

   rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
      .req    (req),
      .ptr    (ptr_reg),
      .gnt    (arb_gnt),
      .winner (winner),
      .any    (arb_any)
   );

`ifdef MEM_WR_ARB_RANGE_CHECK_EN
   assign in_range = word_index(32'(req_addr[winner])) < 32'(NUM_WORDS);
`else
   assign in_range = 1'b1;
`endif

   // Stop granting once the committed plus in-flight writes reach the target,
   // so nothing is written after done.
   assign grant_ok = (state_reg != ST_DONE) &&
                     ((32'(count_reg) + 32'(write_en_reg)) < 32'(NUM_WORDS));

   always_comb begin
      state_next    = state_reg;
      fire          = arb_any & grant_ok;
      gnt           = fire ? arb_gnt : '0;
      write_en_next = fire & in_range;
      err_next      = err_reg | (fire & ~in_range);
      case (state_reg)
         ST_DONE: state_next = ST_DONE;
         default: begin
            if (write_en_reg && (count_reg == CW'(NUM_WORDS - 1)))
               state_next = ST_DONE;
            else if (fire)
               state_next = ST_GRANT;
            else
               state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         ptr_reg      <= PW'(NREQ - 1);
         write_en_reg <= 1'b0;
         addr_reg     <= '0;
         inp_reg      <= '0;
         count_reg    <= '0;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         write_en_reg <= write_en_next;
         err_reg      <= err_next;
         if (fire)
            ptr_reg <= winner;
         if (write_en_next) begin
            addr_reg <= req_addr[winner];
            inp_reg  <= req_data[winner];
         end
         if (write_en_reg && (count_reg < CW'(NUM_WORDS)))
            count_reg <= count_reg + CW'(1);
      end
   end

   assign write_en      = write_en_reg;
   assign addr          = addr_reg;
   assign inp           = inp_reg;
   assign words_written = count_reg;
   assign done          = (state_reg == ST_DONE);
   assign err           = err_reg;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Scoreboard bench for mem_write_arbiter: model predicts grants and pushes expected writes.
module tb_mem_write_arbiter;
   import cnn_mem_pkg::*;

   localparam int NREQ      = 4;
   localparam int WIDTH     = 256;
   localparam int NUM_WORDS = 43;
   localparam int AW        = $clog2(WIDTH);
   localparam int CW        = $clog2(NUM_WORDS + 1);

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [NREQ-1:0]          req_v = '0;
   logic [NREQ-1:0][AW-1:0]  req_addr_v = '0;
   word_bytes_t [NREQ-1:0]   req_data_v = '0;
   logic [NREQ-1:0]          gnt;
   logic                     write_en;
   logic [AW-1:0]            addr;
   word_bytes_t              inp;
   logic [CW-1:0]            words_written;
   logic                     done;
   logic                     err;

   int checks_cnt = 0;
   int errors_cnt = 0;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } wr_t;

   wr_t             exp_q[$];
   logic [NREQ-1:0] gnt_log[$];

   mem_write_arbiter #(
      .NREQ(NREQ), .WIDTH(WIDTH), .NUM_WORDS(NUM_WORDS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req_v), .req_addr(req_addr_v),
      .req_data(req_data_v), .gnt(gnt), .write_en(write_en), .addr(addr),
      .inp(inp), .words_written(words_written), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic refresh(input int i);
      req_addr_v[i] = AW'($urandom_range(0, NUM_WORDS - 1) << 2);
      req_data_v[i] = $urandom;
   endtask

   // Runs n cycles from posedge+1; granted requesters present fresh data next cycle.
   task automatic hold_cycles(input int n);
      logic [NREQ-1:0] g;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         g = gnt;
         gnt_log.push_back(g);
         $display("cycle req=%b gnt=%b write_en=%0b addr=0x%0h inp=0x%08h count=%0d done=%0b",
                  req_v, g, write_en, addr, inp, words_written, done);
         @(posedge clk); #1;
         for (int i = 0; i < NREQ; i++)
            if (g[i]) refresh(i);
      end
   endtask

   // Reference model and scoreboard, evaluated mid-cycle.
   initial begin
      int  m_ptr, m_count, win, idx;
      bit  m_done, m_err, m_wen, nx_wen, inr;
      wr_t e;
      m_ptr = NREQ - 1; m_count = 0; m_done = 0; m_err = 0; m_wen = 0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         check_val("sb_write_en", 64'(write_en), 64'(m_wen));
         if (m_wen) begin
            if (exp_q.size() == 0) begin
               check_val("sb_underflow", 64'(1), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check_val("sb_addr", 64'(addr), 64'(e.a));
               check_val("sb_inp", 64'(inp), 64'(e.d));
            end
         end
         check_val("sb_count", 64'(words_written), 64'(m_count));
         check_val("sb_done", 64'(done), 64'(m_done));
         check_val("sb_err", 64'(err), 64'(m_err));
         win = -1;
         if (!m_done && (m_count + int'(m_wen)) < NUM_WORDS) begin
            for (int k = 1; k <= NREQ; k++) begin
               idx = (m_ptr + k) % NREQ;
               if (win < 0 && req_v[idx]) win = idx;
            end
         end
         check_val("sb_gnt", 64'(gnt), (win >= 0) ? (64'(1) << win) : 64'(0));
         nx_wen = 0;
         if (win >= 0) begin
            m_ptr = win;
`ifdef MEM_WR_ARB_RANGE_CHECK_EN
            inr = (32'(req_addr_v[win]) >> 2) < 32'(NUM_WORDS);
`else
            inr = 1;
`endif
            if (inr) begin
               nx_wen = 1;
               exp_q.push_back('{a: req_addr_v[win], d: req_data_v[win]});
            end else begin
               m_err = 1;
            end
         end
         if (m_wen && m_count < NUM_WORDS) begin
            m_count++;
            if (m_count == NUM_WORDS) m_done = 1;
         end
         m_wen = nx_wen;
         if (!rst_n) begin
            m_ptr = NREQ - 1; m_count = 0; m_done = 0; m_err = 0; m_wen = 0;
            exp_q.delete();
         end
      end
   end

   initial begin
      int n;
      logic [NREQ-1:0] alt_exp[8];
      logic [NREQ-1:0] rr_exp[8];
      alt_exp = '{4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010};
      rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_write_en", 64'(write_en), 64'(0));
      check_val("rst_count", 64'(words_written), 64'(0));
      check_val("rst_done", 64'(done), 64'(0));
      check_val("rst_addr", 64'(addr), 64'(0));
      check_val("rst_inp", 64'(inp), 64'(0));
      check_val("rst_err", 64'(err), 64'(0));
      rst_n = 1'b1;

      // Single requester
      @(posedge clk); #1;
      req_v = 4'b0001;
      req_addr_v[0] = 8'h08;
      req_data_v[0] = '{8'h11, 8'h22, 8'h33, 8'h44};
      @(negedge clk);
      check_val("t1_gnt", 64'(gnt), 64'(4'b0001));
      @(posedge clk); #1;
      req_v = '0;
      @(negedge clk);
      check_val("t1_write_en", 64'(write_en), 64'(1));
      check_val("t1_addr", 64'(addr), 64'(8'h08));
      check_val("t1_word_idx", 64'(addr >> 2), 64'(2));
      check_val("t1_inp", 64'(inp), 64'(32'h11223344));
      $display("single write addr=0x%0h inp=0x%08h", addr, inp);

      // Requesters 1 and 3 with pointer at 1
      @(posedge clk); #1;
      req_v = 4'b0010;
      refresh(1);
      hold_cycles(1);
      refresh(3);
      req_v = 4'b1010;
      gnt_log.delete();
      hold_cycles(8);
      for (int i = 0; i < 8; i++)
         check_val($sformatf("alt_gnt%0d", i), 64'(gnt_log[i]), 64'(alt_exp[i]));
      req_v = '0;
      hold_cycles(2);
      check_val("alt_count", 64'(words_written), 64'(10));

      // Out-of-range word index
      req_v = 4'b0001;
      req_addr_v[0] = 8'hB0;
      req_data_v[0] = 32'hCAFEF00D;
      @(negedge clk);
      check_val("rng_gnt", 64'(gnt), 64'(4'b0001));
      @(posedge clk); #1;
      req_v = '0;
      @(negedge clk);
`ifdef MEM_WR_ARB_RANGE_CHECK_EN
      check_val("rng_write_en", 64'(write_en), 64'(0));
      check_val("rng_err", 64'(err), 64'(1));
      @(negedge clk);
      check_val("rng_count", 64'(words_written), 64'(10));
`else
      check_val("rng_write_en", 64'(write_en), 64'(1));
      check_val("rng_err", 64'(err), 64'(0));
      @(negedge clk);
      check_val("rng_count", 64'(words_written), 64'(11));
`endif
      @(posedge clk); #1;

      // Continuous requests, reset while a write is in flight
      for (int i = 0; i < NREQ; i++) refresh(i);
      req_v = '1;
      hold_cycles(5);
      rst_n = 1'b0;
      @(negedge clk);
      check_val("mid_inflight", 64'(write_en), 64'(1));
      @(posedge clk); #1;
      check_val("mid_write_en", 64'(write_en), 64'(0));
      check_val("mid_count", 64'(words_written), 64'(0));
      check_val("mid_done", 64'(done), 64'(0));
      check_val("mid_err", 64'(err), 64'(0));
      rst_n = 1'b1;

      // Four requesters from reset through done
      gnt_log.delete();
      hold_cycles(8);
      for (int i = 0; i < 8; i++)
         check_val($sformatf("rr_gnt%0d", i), 64'(gnt_log[i]), 64'(rr_exp[i]));
      n = 8;
      while (!done && n < 100) begin
         hold_cycles(1);
         n++;
      end
      check_val("done_cycle", 64'(n), 64'(44));
      check_val("done_count", 64'(words_written), 64'(NUM_WORDS));
      gnt_log.delete();
      hold_cycles(3);
      for (int i = 0; i < 3; i++)
         check_val($sformatf("done_gnt%0d", i), 64'(gnt_log[i]), 64'(0));
      check_val("done_sticky", 64'(done), 64'(1));
      check_val("done_count_hold", 64'(words_written), 64'(NUM_WORDS));
      req_v = '0;
      hold_cycles(1);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule

// File: doc/mem_write_arbiter.md
# mem_write_arbiter

Round-robin scheduler that shares the single write port of `write_memory` between `NREQ` processing elements, each producing 4-byte output words. It drives `write_en`, `addr` and `inp` directly into `write_memory`. It counts committed words and raises `done` once `NUM_WORDS` words have been written, which triggers the memory's output-file dump. It sits between the CNN PE array and the output memory.

## Interface
- `NREQ`, 4: number of requesters (≥2).
- `WIDTH`, 64: memory `WIDTH` parameter; address width is `$clog2(WIDTH)`.
- `NUM_WORDS`, 43: words that must be committed before `done`.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset; one clock; synchronous, active-low.
- `req` input NREQ: per-requester write request; held until granted.
- `req_addr` input [NREQ][$clog2(WIDTH)]: byte address; word index = `req_addr >> 2`.
- `req_data` input [NREQ][0:3][7:0]: bytes; byte 0 → bits [31:24] in memory.
- `gnt` output NREQ: one-hot, combinational; request consumed at the edge ending this cycle.
- `write_en` output 1: registered write strobe to memory.
- `addr` output $clog2(WIDTH): registered byte address to memory.
- `inp` output [0:3][7:0]: registered data to memory.
- `words_written` output $clog2(NUM_WORDS+1): committed-word count.
- `done` output 1: high once count reaches `NUM_WORDS`; sticky until reset.
- `err` output 1: sticky out-of-range flag (tied 0 when check compiled out).

## Operation
- Reset (`rst_n`=0 at edge): `write_en`=0, `addr`=0, `inp`=all 0, `words_written`=0, `done`=0, `err`=0, RR pointer = NREQ-1, so requester 0 has first priority.
- States: IDLE (no req), GRANT (≥1 req, not done), DONE.
- Arbitration: search starts at pointer+1 mod NREQ and wraps; the first asserted `req` wins. On a grant, pointer ← winner index.
- At most one grant per cycle. Losers hold `req`, `req_addr` and `req_data` stable.
- A granted requester may keep `req` high with new data in the next cycle; it is treated as a new request and competes normally. Round-robin prevents back-to-back wins while others wait.
- The grant edge latches the winner's addr/data into the output regs and sets `write_en`=1 for exactly one cycle. With no grant, `write_en`=0 and addr/inp hold their values.
- `words_written` increments on each cycle where `write_en`=1, saturating at NUM_WORDS.
- `done` is set in the cycle `words_written` becomes NUM_WORDS. In DONE, `gnt`=0 for all requesters and no further writes occur.
- Reset mid-transfer: an in-flight `write_en` is squashed (0 after the reset edge); count, pointer and `done` are cleared.

## Timing
- Latency: req high in cycle t → `gnt` in cycle t (combinational) → `write_en`/`addr`/`inp` valid in cycle t+1 → memory write at the end of t+1.
- Throughput: 1 word/cycle under continuous requests.
- `done` rises the cycle after the final `write_en` cycle, so the final memory write is already committed when `done` rises.
- No combinational path from `req` to `write_en`.

## Configuration
- `MEM_WR_ARB_RANGE_CHECK_EN` defined: a granted request with word index (`req_addr >> 2`) ≥ NUM_WORDS is consumed (`gnt` pulses) but produces no `write_en` and no count increment. `err` is set and held until reset.
- Undefined: the address passes unchecked, every grant writes and counts, and `err`=0 constantly.

## Structure
- Shared package `cnn_mem_pkg`: `byte_t` (logic [7:0]), `word_bytes_t` (byte_t [0:3]), `WORD_BYTES`=4, `DEFAULT_NUM_WORDS`=43.
- Sub-module `rr_arbiter` (params NREQ): inputs `req` and `ptr`; outputs one-hot `gnt`, `winner` index and `any`. Purely combinational. The pointer register lives in the parent.

## Test plan
- Single requester: req[0] with addr 0x08, data {0x11,0x22,0x33,0x44} → gnt[0] same cycle; next cycle write_en=1, addr=0x08, inp={11,22,33,44}; memory word 2 = 0x11223344.
- Four requesters held continuously from reset → grant order 0,1,2,3,0,…; write_en high every cycle; 43 writes → done=1 one cycle after the 43rd write_en; gnt=0 afterwards.
- Requesters 1 and 3 only, pointer at 1 → grants alternate 3,1,3,1; no requester starves.
- Reset pulled low during a cycle with write_en=1 → next cycle write_en=0, words_written=0, done=0, first grant goes to requester 0.
- With `MEM_WR_ARB_RANGE_CHECK_EN`: addr 0xB0 (word 44) → gnt pulses, write_en stays 0, err=1, count unchanged. Without the macro → write_en=1 and count+1.
